// File: rtl/jogo_pkg.sv
// Shared defaults and elaboration helpers for the memory-game datapath.
// Provides the default W/DEPTH values, the counter-width helper used to derive
// AW and the timeout counter width, and the built-in ROM image.
package jogo_pkg;

  localparam int JOGO_W_DEFAULT     = 4;
  localparam int JOGO_DEPTH_DEFAULT = 16;

  // Width needed to count 0..n-1.
  // Never returns less than one bit, so tiny depths still get a real register.
  function automatic int jogo_addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Default sequence image.
  // The pattern repeats every 16 entries; callers truncate each word to W bits.
  function automatic logic [31:0] jogo_rom_word(input int unsigned addr);
    logic [31:0] word;
    case (addr % 16)
      0:       word = 32'h1;
      1:       word = 32'h2;
      2:       word = 32'h4;
      3:       word = 32'h2;
      4:       word = 32'h8;
      5:       word = 32'h1;
      6:       word = 32'h4;
      7:       word = 32'h8;
      8:       word = 32'h2;
      9:       word = 32'h1;
      10:      word = 32'h8;
      11:      word = 32'h4;
      12:      word = 32'h1;
      13:      word = 32'h2;
      14:      word = 32'h4;
      default: word = 32'h8;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/detector_jogada.sv
// Play detector: a 2-flop synchroniser on the raw switches, followed by an
// edge flop that remembers whether a play was already seen.
// Ports:
//   clock, reset_n  clock / asynchronous active-low reset
//   chaves   [W]    raw switches, asynchronous to clock
//   rearm           round restart; masks switches that are still held
//   s        [W]    synchronised switches
//   tem_jogada      |s
//   jogada_feita    single-cycle pulse when s goes from zero to nonzero
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int W = JOGO_W_DEFAULT
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] chaves,
  input  logic         rearm,
  output logic [W-1:0] s,
  output logic         tem_jogada,
  output logic         jogada_feita
);

  logic [W-1:0] s_p0;
  logic [W-1:0] s_p1;
  logic         p_p2;

  // p0/p1: metastability filter on the asynchronous switches
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_p0 <= '0;
      s_p1 <= '0;
    end else begin
      s_p0 <= chaves;
      s_p1 <= s_p0;
    end
  end

  // p2: play-seen flag
  // A restart forces the flag set, so switches held across the restart are
  // treated as already seen and raise no pulse until released and pressed again.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_p2 <= 1'b0;
    end else if (rearm) begin
      p_p2 <= 1'b1;
    end else begin
      p_p2 <= |s_p1;
    end
  end

  assign s            = s_p1;
  assign tem_jogada   = |s_p1;
  assign jogada_feita = (|s_p1) & ~p_p2;

endmodule

// File: rtl/fluxo_dados_jogo_n.sv
// Memory-game datapath, driven by the game control unit.
// Contents:
//   - address counter E and limit counter L, both wrapping after DEPTH-1
//   - play register R
//   - registered ROM indexed by E
//   - play detector
//   - optional per-play timeout counter T
// The ROM contents come from the jogo_pkg image. MEM_FILE names the
// equivalent hex memory-image file for FPGA flows and is not read here.
// Optional feature: define JOGO_TIMEOUT_EN to build T; otherwise timeout is
// tied low and zeraT/contaT are ignored.
// Ports:
//   clock, reset_n            clock / asynchronous active-low reset
//   chaves [W]                raw player switches
//   zeraE/contaE              clear / count for E (clear wins)
//   zeraL/contaL              clear / count for L (clear wins)
//   zeraR/registraR           clear / load for R (clear wins)
//   zeraT/contaT              clear / count for T (clear wins)
//   igual                     ROM output register == R
//   enderecoIgualLimite       E == L
//   fimE, fimL                E / L at DEPTH-1
//   jogada_feita              one-cycle new-play pulse
//   timeout                   play time exhausted
//   db_tem_jogada             any synchronised switch set
//   db_jogada [W]             R
//   db_contagem, db_limite    E and L [AW]
//   db_memoria [W]            ROM output register
module fluxo_dados_jogo_n
  import jogo_pkg::*;
#(
  parameter int    W              = JOGO_W_DEFAULT,
  parameter int    DEPTH          = JOGO_DEPTH_DEFAULT,
  parameter string MEM_FILE       = "jogo.hex",
  parameter int    TIMEOUT_CYCLES = 5000,
  localparam int   AW             = jogo_addr_w(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [W-1:0]  chaves,
  input  logic          zeraE,
  input  logic          contaE,
  input  logic          zeraL,
  input  logic          contaL,
  input  logic          zeraR,
  input  logic          registraR,
  input  logic          zeraT,
  input  logic          contaT,
  output logic          igual,
  output logic          enderecoIgualLimite,
  output logic          fimE,
  output logic          fimL,
  output logic          jogada_feita,
  output logic          timeout,
  output logic          db_tem_jogada,
  output logic [W-1:0]  db_jogada,
  output logic [AW-1:0] db_contagem,
  output logic [AW-1:0] db_limite,
  output logic [W-1:0]  db_memoria
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] e_q;
  logic [AW-1:0] l_q;
  logic [W-1:0]  r_q;
  logic [W-1:0]  rom_q;
  logic [W-1:0]  s_sync;

  // Address and limit counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      e_q <= '0;
    end else if (zeraE) begin
      e_q <= '0;
    end else if (contaE) begin
      e_q <= (e_q == LAST) ? '0 : e_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      l_q <= '0;
    end else if (zeraL) begin
      l_q <= '0;
    end else if (contaL) begin
      l_q <= (l_q == LAST) ? '0 : l_q + 1'b1;
    end
  end

  // Play register: loads the synchronised switches, never the raw pins
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (zeraR) begin
      r_q <= '0;
    end else if (registraR) begin
      r_q <= s_sync;
    end
  end

  // Synchronous ROM: one cycle from E to db_memoria
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rom_q <= '0;
    end else begin
      rom_q <= W'(jogo_rom_word(32'(e_q)));
    end
  end

  detector_jogada #(
    .W (W)
  ) u_detector (
    .clock        (clock),
    .reset_n      (reset_n),
    .chaves       (chaves),
    .rearm        (zeraE),
    .s            (s_sync),
    .tem_jogada   (db_tem_jogada),
    .jogada_feita (jogada_feita)
  );

`ifdef JOGO_TIMEOUT_EN
  localparam int            TW     = jogo_addr_w(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] t_q;

  // Timeout counter saturates so timeout stays asserted until cleared
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      t_q <= '0;
    end else if (zeraT) begin
      t_q <= '0;
    end else if (contaT && (t_q != T_LAST)) begin
      t_q <= t_q + 1'b1;
    end
  end

  assign timeout = (t_q == T_LAST);
`else
  logic unused_timeout_ctrl;
  assign unused_timeout_ctrl = zeraT ^ contaT;
  assign timeout             = 1'b0;
`endif

  assign igual               = (rom_q == r_q);
  assign enderecoIgualLimite = (e_q == l_q);
  assign fimE                = (e_q == LAST);
  assign fimL                = (l_q == LAST);
  assign db_jogada           = r_q;
  assign db_contagem         = e_q;
  assign db_limite           = l_q;
  assign db_memoria          = rom_q;

endmodule
